// File: rtl/seq_counter_if.sv
// Control/status bundle between the game controller and seq_counter.
// Carries the BCD score digits only when SEQ_COUNTER_BCD_EN is defined.
interface seq_counter_if #(
  parameter int WIDTH = 5
);
  logic             clear;
  logic             increment;
  logic             decrement;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             at_limit;
  logic             at_max;
  logic             reached;
  logic             ovf;
  logic             unf;
`ifdef SEQ_COUNTER_BCD_EN
  logic [3:0]       bcd_tens;
  logic [3:0]       bcd_ones;

  modport master (
    output clear, increment, decrement, load, load_value, limit,
    input  count, at_limit, at_max, reached, ovf, unf, bcd_tens, bcd_ones
  );
  modport slave (
    input  clear, increment, decrement, load, load_value, limit,
    output count, at_limit, at_max, reached, ovf, unf, bcd_tens, bcd_ones
  );
`else
  modport master (
    output clear, increment, decrement, load, load_value, limit,
    input  count, at_limit, at_max, reached, ovf, unf
  );
  modport slave (
    input  clear, increment, decrement, load, load_value, limit,
    output count, at_limit, at_max, reached, ovf, unf
  );
`endif
endinterface

// File: rtl/seq_counter.sv
// Round/position counter with load, up/down, wrap or saturate at MAX_COUNT and event pulses.
// Optional BCD score digits are built when SEQ_COUNTER_BCD_EN is defined.
module seq_counter #(
  parameter int WIDTH     = 5,
  parameter int MAX_COUNT = 31,
  parameter bit WRAP      = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  seq_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ZERO_C  = {WIDTH{1'b0}};

  typedef enum logic [2:0] {
    OP_IDLE  = 3'd0,
    OP_CLEAR = 3'd1,
    OP_LOAD  = 3'd2,
    OP_INC   = 3'd3,
    OP_DEC   = 3'd4
  } op_e;

  generate
    if (MAX_COUNT < 1 || MAX_COUNT > (2 ** WIDTH) - 1) begin : g_bad_max
      $error("seq_counter: MAX_COUNT must be in 1 .. 2**WIDTH-1");
    end
  endgenerate

  logic [WIDTH-1:0] count_q, count_d;
  logic             reached_q, reached_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH:0]   inc_ext_s;
  logic [WIDTH:0]   dec_ext_s;
  logic [WIDTH-1:0] load_clamp_s;
  op_e              op_s;

  // Arithmetic is one bit wider than count so the ceiling test never truncates.
  assign inc_ext_s = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_ext_s = {1'b0, count_q} - {{WIDTH{1'b0}}, 1'b1};

  // Clamp load_value to the configured ceiling
  always_comb begin
    if ({1'b0, bus.load_value} > MAX_EXT) begin
      load_clamp_s = MAX_C;
    end else begin
      load_clamp_s = bus.load_value;
    end
  end

  // Resolve the per-cycle operation; clear beats load beats a lone inc/dec
  always_comb begin
    op_s = OP_IDLE;
    if (bus.clear) begin
      op_s = OP_CLEAR;
    end else if (bus.load) begin
      op_s = OP_LOAD;
    end else if (bus.increment && !bus.decrement) begin
      op_s = OP_INC;
    end else if (bus.decrement && !bus.increment) begin
      op_s = OP_DEC;
    end else begin
      op_s = OP_IDLE;
    end
  end

  // Next count and event pulses
  always_comb begin
    count_d   = count_q;
    reached_d = 1'b0;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    case (op_s)
      OP_CLEAR: count_d = ZERO_C;
      OP_LOAD:  count_d = load_clamp_s;
      OP_INC: begin
        if (inc_ext_s > MAX_EXT) begin
          ovf_d   = 1'b1;
          count_d = WRAP ? ZERO_C : count_q;
        end else begin
          count_d = inc_ext_s[WIDTH-1:0];
        end
        // A saturated hold on the limit is not a fresh arrival.
        reached_d = (count_d == bus.limit) && (count_q != bus.limit);
      end
      OP_DEC: begin
        if (count_q == ZERO_C) begin
          unf_d   = 1'b1;
          count_d = WRAP ? MAX_C : count_q;
        end else begin
          count_d = dec_ext_s[WIDTH-1:0];
        end
      end
      default: count_d = count_q;
    endcase
  end

  // Count and pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= ZERO_C;
      reached_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      reached_q <= reached_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.reached  = reached_q;
  assign bus.ovf      = ovf_q;
  assign bus.unf      = unf_q;
  assign bus.at_limit = (count_q == bus.limit);
  assign bus.at_max   = (count_q == MAX_C);

`ifdef SEQ_COUNTER_BCD_EN
  localparam logic [3:0] MAX_TENS = 4'(MAX_COUNT / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_COUNT % 10);

  generate
    if (MAX_COUNT > 99) begin : g_bad_bcd
      $error("seq_counter: BCD digits need MAX_COUNT <= 99");
    end
  endgenerate

  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    logic [6:0] tens;
    logic [6:0] ones;
    tens = v / 7'd10;
    ones = v % 7'd10;
    return {tens[3:0], ones[3:0]};
  endfunction

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;

  // Digits track count step by step; only load goes through a conversion
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    case (op_s)
      OP_CLEAR: begin
        tens_d = 4'd0;
        ones_d = 4'd0;
      end
      OP_LOAD: {tens_d, ones_d} = bin2bcd(7'(load_clamp_s));
      OP_INC: begin
        if (inc_ext_s > MAX_EXT) begin
          tens_d = WRAP ? 4'd0 : tens_q;
          ones_d = WRAP ? 4'd0 : ones_q;
        end else if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end
      OP_DEC: begin
        if (count_q == ZERO_C) begin
          tens_d = WRAP ? MAX_TENS : tens_q;
          ones_d = WRAP ? MAX_ONES : ones_q;
        end else if (ones_q == 4'd0) begin
          ones_d = 4'd9;
          tens_d = tens_q - 4'd1;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end
      default: begin
        tens_d = tens_q;
        ones_d = ones_q;
      end
    endcase
  end

  // BCD digit registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign bus.bcd_tens = tens_q;
  assign bus.bcd_ones = ones_q;
`endif

endmodule

// File: tb/tb_seq_counter.sv
// Bench for seq_counter: a saturating 6-bit/31 instance and a wrapping 4-bit/9 instance,
// directed scenarios plus randomized traffic against an integer reference model.
module tb_seq_counter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  seq_counter_if #(.WIDTH(6)) a_if ();
  seq_counter_if #(.WIDTH(4)) b_if ();

  seq_counter #(.WIDTH(6), .MAX_COUNT(31), .WRAP(1'b0)) dut_a (
    .clk(clk), .reset(reset), .bus(a_if.slave)
  );
  seq_counter #(.WIDTH(4), .MAX_COUNT(9), .WRAP(1'b1)) dut_b (
    .clk(clk), .reset(reset), .bus(b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  int a_cnt, b_cnt;
  bit a_rch, a_ovf, a_unf, b_rch, b_ovf, b_unf;

  function automatic void model_step(
    input int cnt, input int maxc, input int lim, input bit wrap,
    input bit rst, input bit clr, input bit ld, input int lv,
    input bit inc, input bit dec,
    output int ncnt, output bit nrch, output bit novf, output bit nunf);
    ncnt = cnt; nrch = 1'b0; novf = 1'b0; nunf = 1'b0;
    if (rst || clr) ncnt = 0;
    else if (ld) ncnt = (lv > maxc) ? maxc : lv;
    else if (inc && !dec) begin
      novf = (cnt == maxc);
      if (wrap) ncnt = (cnt + 1) % (maxc + 1);
      else      ncnt = (cnt + 1 > maxc) ? maxc : cnt + 1;
      nrch = (ncnt == lim) && (cnt != lim);
    end else if (dec && !inc) begin
      nunf = (cnt == 0);
      if (wrap) ncnt = (cnt + maxc) % (maxc + 1);
      else      ncnt = (cnt == 0) ? 0 : cnt - 1;
    end
  endfunction

  task automatic tick();
    int na, nb;
    bit ra, oa, ua, rb, ob, ub;
    model_step(a_cnt, 31, int'(a_if.limit), 1'b0, reset, a_if.clear, a_if.load,
               int'(a_if.load_value), a_if.increment, a_if.decrement, na, ra, oa, ua);
    model_step(b_cnt, 9, int'(b_if.limit), 1'b1, reset, b_if.clear, b_if.load,
               int'(b_if.load_value), b_if.increment, b_if.decrement, nb, rb, ob, ub);
    @(posedge clk);
    #1;
    a_cnt = na; a_rch = ra; a_ovf = oa; a_unf = ua;
    b_cnt = nb; b_rch = rb; b_ovf = ob; b_unf = ub;
  endtask

  task automatic idle_inputs();
    reset = 1'b0;
    a_if.clear = 1'b0; a_if.increment = 1'b0; a_if.decrement = 1'b0; a_if.load = 1'b0;
    b_if.clear = 1'b0; b_if.increment = 1'b0; b_if.decrement = 1'b0; b_if.load = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    a_if.load_value = 6'd0; a_if.limit = 6'd5;
    b_if.load_value = 4'd0; b_if.limit = 4'd3;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({a_if.count, a_if.reached, a_if.ovf, a_if.unf, a_if.at_max} !== {6'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_a: got count=%0d r=%b o=%b u=%b m=%b, want 0 0 0 0 0",
               a_if.count, a_if.reached, a_if.ovf, a_if.unf, a_if.at_max);
    end
    checks++;
    if ({b_if.count, b_if.reached, b_if.ovf, b_if.unf} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_b: got count=%0d r=%b o=%b u=%b, want 0 0 0 0",
               b_if.count, b_if.reached, b_if.ovf, b_if.unf);
    end
  endtask

  task automatic test_count_to_limit();
    idle_inputs();
    a_if.limit = 6'd5;
    a_if.increment = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (a_if.count !== 6'(i) || a_if.reached !== (i == 5)) begin
        errors++;
        $display("FAIL count_up step %0d: got count=%0d reached=%b, want %0d %b",
                 i, a_if.count, a_if.reached, i, (i == 5));
      end
    end
    checks++;
    if (a_if.at_limit !== 1'b1) begin
      errors++;
      $display("FAIL at_limit: got %b, want 1", a_if.at_limit);
    end
    a_if.increment = 1'b0;
    tick();
    checks++;
    if (a_if.reached !== 1'b0 || a_if.count !== 6'd5) begin
      errors++;
      $display("FAIL reached_one_cycle: got reached=%b count=%0d, want 0 5", a_if.reached, a_if.count);
    end
  endtask

  task automatic test_saturate();
    idle_inputs();
    a_if.load = 1'b1; a_if.load_value = 6'd31;
    tick();
    a_if.load = 1'b0; a_if.increment = 1'b1; a_if.limit = 6'd31;
    tick();
    checks++;
    if ({a_if.count, a_if.ovf, a_if.reached, a_if.at_max} !== {6'd31, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sat_inc: got count=%0d ovf=%b reached=%b at_max=%b, want 31 1 0 1",
               a_if.count, a_if.ovf, a_if.reached, a_if.at_max);
    end
    a_if.increment = 1'b0;
    tick();
    checks++;
    if (a_if.ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_one_cycle: got %b, want 0", a_if.ovf);
    end
    a_if.load = 1'b1; a_if.load_value = 6'd0;
    tick();
    a_if.load = 1'b0; a_if.decrement = 1'b1;
    tick();
    checks++;
    if ({a_if.count, a_if.unf} !== {6'd0, 1'b1}) begin
      errors++;
      $display("FAIL sat_dec: got count=%0d unf=%b, want 0 1", a_if.count, a_if.unf);
    end
  endtask

  task automatic test_wrap();
    idle_inputs();
    b_if.load = 1'b1; b_if.load_value = 4'd9;
    tick();
    b_if.load = 1'b0; b_if.increment = 1'b1; b_if.limit = 4'd0;
    tick();
    checks++;
    if ({b_if.count, b_if.ovf, b_if.reached} !== {4'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL wrap_inc: got count=%0d ovf=%b reached=%b, want 0 1 1",
               b_if.count, b_if.ovf, b_if.reached);
    end
    b_if.increment = 1'b0; b_if.decrement = 1'b1;
    tick();
    checks++;
    if ({b_if.count, b_if.unf, b_if.ovf, b_if.reached} !== {4'd9, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL wrap_dec: got count=%0d unf=%b ovf=%b reached=%b, want 9 1 0 0",
               b_if.count, b_if.unf, b_if.ovf, b_if.reached);
    end
  endtask

  task automatic test_simultaneous();
    idle_inputs();
    a_if.limit = 6'd7;
    a_if.load = 1'b1; a_if.load_value = 6'd6;
    tick();
    a_if.load = 1'b0; a_if.increment = 1'b1;
    tick();
    a_if.decrement = 1'b1;
    tick();
    checks++;
    if ({a_if.count, a_if.reached, a_if.ovf, a_if.unf} !== {6'd7, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL inc_dec_hold: got count=%0d r=%b o=%b u=%b, want 7 0 0 0",
               a_if.count, a_if.reached, a_if.ovf, a_if.unf);
    end
    a_if.decrement = 1'b0; a_if.load = 1'b1; a_if.load_value = 6'd3;
    tick();
    checks++;
    if (a_if.count !== 6'd3) begin
      errors++;
      $display("FAIL load_over_inc: got %0d, want 3", a_if.count);
    end
    a_if.increment = 1'b0; a_if.clear = 1'b1; a_if.load_value = 6'd12;
    tick();
    checks++;
    if (a_if.count !== 6'd0) begin
      errors++;
      $display("FAIL clear_over_load: got %0d, want 0", a_if.count);
    end
    a_if.clear = 1'b0; a_if.load_value = 6'd40; a_if.limit = 6'd40;
    tick();
    checks++;
    if ({a_if.count, a_if.at_limit} !== {6'd31, 1'b0}) begin
      errors++;
      $display("FAIL load_clamp: got count=%0d at_limit=%b, want 31 0", a_if.count, a_if.at_limit);
    end
    a_if.load = 1'b0; a_if.increment = 1'b1;
    tick();
    checks++;
    if ({a_if.reached, a_if.ovf} !== {1'b0, 1'b1}) begin
      errors++;
      $display("FAIL limit_above_max: got reached=%b ovf=%b, want 0 1", a_if.reached, a_if.ovf);
    end
  endtask

  task automatic test_reset_priority();
    idle_inputs();
    a_if.limit = 6'd5;
    a_if.load = 1'b1; a_if.load_value = 6'd4;
    tick();
    a_if.load = 1'b0; a_if.increment = 1'b1; reset = 1'b1;
    tick();
    checks++;
    if ({a_if.count, a_if.reached} !== {6'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_beats_inc: got count=%0d reached=%b, want 0 0", a_if.count, a_if.reached);
    end
    reset = 1'b0; a_if.increment = 1'b0; a_if.load = 1'b1; a_if.load_value = 6'd31;
    tick();
    a_if.load = 1'b0; a_if.increment = 1'b1; a_if.clear = 1'b1;
    tick();
    checks++;
    if ({a_if.count, a_if.ovf} !== {6'd0, 1'b0}) begin
      errors++;
      $display("FAIL clear_cancels_ovf: got count=%0d ovf=%b, want 0 0", a_if.count, a_if.ovf);
    end
  endtask

  task automatic test_random();
    logic [5:0] exp_a;
    logic [3:0] exp_b;
    idle_inputs();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      a_if.clear = ($urandom_range(0, 29) == 0);
      a_if.load = ($urandom_range(0, 9) == 0);
      a_if.increment = ($urandom_range(0, 1) == 0);
      a_if.decrement = ($urandom_range(0, 3) == 0);
      a_if.load_value = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) a_if.limit = 6'($urandom_range(0, 35));
      b_if.clear = ($urandom_range(0, 29) == 0);
      b_if.load = ($urandom_range(0, 9) == 0);
      b_if.increment = ($urandom_range(0, 1) == 0);
      b_if.decrement = ($urandom_range(0, 2) == 0);
      b_if.load_value = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) b_if.limit = 4'($urandom_range(0, 11));
      tick();
      exp_a = 6'(a_cnt);
      exp_b = 4'(b_cnt);
      checks++;
      if ({a_if.count, a_if.reached, a_if.ovf, a_if.unf, a_if.at_limit, a_if.at_max} !==
          {exp_a, a_rch, a_ovf, a_unf, (a_cnt == int'(a_if.limit)), (a_cnt == 31)}) begin
        errors++;
        $display("FAIL rand_a cyc %0d: got c=%0d r=%b o=%b u=%b l=%b m=%b, want c=%0d r=%b o=%b u=%b",
                 n, a_if.count, a_if.reached, a_if.ovf, a_if.unf, a_if.at_limit, a_if.at_max,
                 a_cnt, a_rch, a_ovf, a_unf);
      end
      checks++;
      if ({b_if.count, b_if.reached, b_if.ovf, b_if.unf, b_if.at_limit, b_if.at_max} !==
          {exp_b, b_rch, b_ovf, b_unf, (b_cnt == int'(b_if.limit)), (b_cnt == 9)}) begin
        errors++;
        $display("FAIL rand_b cyc %0d: got c=%0d r=%b o=%b u=%b l=%b m=%b, want c=%0d r=%b o=%b u=%b",
                 n, b_if.count, b_if.reached, b_if.ovf, b_if.unf, b_if.at_limit, b_if.at_max,
                 b_cnt, b_rch, b_ovf, b_unf);
      end
`ifdef SEQ_COUNTER_BCD_EN
      checks++;
      if ({a_if.bcd_tens, a_if.bcd_ones, b_if.bcd_tens, b_if.bcd_ones} !==
          {4'(a_cnt / 10), 4'(a_cnt % 10), 4'(b_cnt / 10), 4'(b_cnt % 10)}) begin
        errors++;
        $display("FAIL rand_bcd cyc %0d: got a=%0d%0d b=%0d%0d, want a=%0d b=%0d", n,
                 a_if.bcd_tens, a_if.bcd_ones, b_if.bcd_tens, b_if.bcd_ones, a_cnt, b_cnt);
      end
`endif
    end
  endtask

`ifdef SEQ_COUNTER_BCD_EN
  task automatic test_bcd();
    idle_inputs();
    a_if.load = 1'b1; a_if.load_value = 6'd9;
    tick();
    a_if.load = 1'b0; a_if.increment = 1'b1;
    tick();
    checks++;
    if ({a_if.bcd_tens, a_if.bcd_ones} !== {4'd1, 4'd0}) begin
      errors++;
      $display("FAIL bcd_carry: got %0d %0d, want 1 0", a_if.bcd_tens, a_if.bcd_ones);
    end
    a_if.increment = 1'b0; a_if.load = 1'b1; a_if.load_value = 6'd27;
    tick();
    checks++;
    if ({a_if.bcd_tens, a_if.bcd_ones} !== {4'd2, 4'd7}) begin
      errors++;
      $display("FAIL bcd_load: got %0d %0d, want 2 7", a_if.bcd_tens, a_if.bcd_ones);
    end
    a_if.load_value = 6'd20;
    tick();
    a_if.load = 1'b0; a_if.decrement = 1'b1;
    tick();
    checks++;
    if ({a_if.bcd_tens, a_if.bcd_ones} !== {4'd1, 4'd9}) begin
      errors++;
      $display("FAIL bcd_borrow: got %0d %0d, want 1 9", a_if.bcd_tens, a_if.bcd_ones);
    end
    a_if.decrement = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    a_cnt = 0; b_cnt = 0;
    a_rch = 1'b0; a_ovf = 1'b0; a_unf = 1'b0;
    b_rch = 1'b0; b_ovf = 1'b0; b_unf = 1'b0;
    test_reset();
    test_count_to_limit();
    test_saturate();
    test_wrap();
    test_simultaneous();
    test_reset_priority();
`ifdef SEQ_COUNTER_BCD_EN
    test_bcd();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
